// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Purpose  : E-stage multiply/divide unit. Owns the architectural HI/LO
//            registers, executes mult/div with a fixed busy latency counted by
//            an internal down-counter, and provides the MFHI/MFLO read port.
// Ports    : clk    - system clock, rising edge
//            reset  - asynchronous active-high reset, clears all state
//            enMDU  - start strobe from E-stage decode
//            MDUOp  - 4-bit op code (0 NOP .. 12 MSUBU)
//            A, B   - forwarded rs / rt operands
//            req    - exception/interrupt flush of the E-stage instruction
//            busy   - multi-cycle operation in progress
//            MDOut  - HI on MFHI, LO on MFLO, else 0 (combinational)
//            HI, LO - current HI / LO registers
// Options  : `define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU; when left
//            undefined those op codes behave as NOP.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enMDU,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] MDOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] c_OP_NOP   = 4'd0;
  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MFHI  = 4'd5;
  localparam logic [3:0] c_OP_MFLO  = 4'd6;
  localparam logic [3:0] c_OP_MTHI  = 4'd7;
  localparam logic [3:0] c_OP_MTLO  = 4'd8;
  localparam logic [3:0] c_OP_MADD  = 4'd9;
  localparam logic [3:0] c_OP_MADDU = 4'd10;
  localparam logic [3:0] c_OP_MSUB  = 4'd11;
  localparam logic [3:0] c_OP_MSUBU = 4'd12;

  localparam int c_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CW   = $clog2(c_MAXC + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nx;
  logic [c_CW-1:0] r_cnt;
  logic [3:0]      r_op;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;

  logic            w_go;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_done;
  logic            w_wr;
  logic [31:0]     w_hi_nx;
  logic [31:0]     w_lo_nx;

  assign w_go   = enMDU & ~req & ~busy;
  assign w_done = (r_state == S_BUSY) && (r_cnt == c_CW'(1));

  // Decode of ops that enter the BUSY state.
  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    case (MDUOp)
      c_OP_MULT, c_OP_MULTU: w_is_mul = 1'b1;
`ifdef MDU_MADD_EN
      c_OP_MADD, c_OP_MADDU,
      c_OP_MSUB, c_OP_MSUBU: w_is_mul = 1'b1;
`endif
      c_OP_DIV, c_OP_DIVU:   w_is_div = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath on the captured operands
  // --------------------------------------------------------------------------
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

`ifdef MDU_MADD_EN
  // Accumulate base is the HI/LO value present at the completion edge.
  logic [63:0] w_acc;
  assign w_acc = {r_hi, r_lo};
`endif

  // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow corner
  // and gives truncation toward zero with a dividend-signed remainder.
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  assign w_a_mag = r_a[31] ? (32'd0 - r_a) : r_a;
  assign w_b_mag = r_b[31] ? (32'd0 - r_b) : r_b;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_q_s   = (r_a[31] ^ r_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r_s   = r_a[31] ? (32'd0 - w_r_mag) : w_r_mag;

  // Next HI/LO: either a completing multi-cycle result or an IDLE move-to.
  always_comb begin
    w_wr    = 1'b0;
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (w_done) begin
      case (r_op)
        c_OP_MULT:  begin w_wr = 1'b1; {w_hi_nx, w_lo_nx} = w_prod_s; end
        c_OP_MULTU: begin w_wr = 1'b1; {w_hi_nx, w_lo_nx} = w_prod_u; end
`ifdef MDU_MADD_EN
        c_OP_MADD:  begin w_wr = 1'b1; {w_hi_nx, w_lo_nx} = w_acc + w_prod_s; end
        c_OP_MADDU: begin w_wr = 1'b1; {w_hi_nx, w_lo_nx} = w_acc + w_prod_u; end
        c_OP_MSUB:  begin w_wr = 1'b1; {w_hi_nx, w_lo_nx} = w_acc - w_prod_s; end
        c_OP_MSUBU: begin w_wr = 1'b1; {w_hi_nx, w_lo_nx} = w_acc - w_prod_u; end
`endif
        c_OP_DIV: begin
          if (r_b != 32'd0) begin
            w_wr    = 1'b1;
            w_lo_nx = w_q_s;
            w_hi_nx = w_r_s;
          end
        end
        c_OP_DIVU: begin
          if (r_b != 32'd0) begin
            w_wr    = 1'b1;
            w_lo_nx = r_a / r_b;
            w_hi_nx = r_a % r_b;
          end
        end
        default: ;
      endcase
    end else if (w_go && (MDUOp == c_OP_MTHI)) begin
      w_wr    = 1'b1;
      w_hi_nx = A;
    end else if (w_go && (MDUOp == c_OP_MTLO)) begin
      w_wr    = 1'b1;
      w_lo_nx = A;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_go && (w_is_mul || w_is_div)) w_state_nx = S_BUSY;
      S_BUSY:  if (r_cnt == c_CW'(1))              w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_BUSY);
  end

  // Counter, captured operands and HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= c_OP_NOP;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else begin
      if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - c_CW'(1);
      end else if (w_go && (w_is_mul || w_is_div)) begin
        r_cnt <= w_is_div ? c_CW'(DIV_CYCLES) : c_CW'(MULT_CYCLES);
        r_op  <= MDUOp;
        r_a   <= A;
        r_b   <= B;
      end
      if (w_wr) begin
        r_hi <= w_hi_nx;
        r_lo <= w_lo_nx;
      end
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

  always_comb begin
    MDOut = 32'd0;
    if (MDUOp == c_OP_MFHI)      MDOut = r_hi;
    else if (MDUOp == c_OP_MFLO) MDOut = r_lo;
  end

endmodule
`default_nettype wire

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multiply/divide unit in the E stage. Consumes the E-stage controller's enMDU/MDUOp decode together with forwarded register operands. Owns the architectural HI/LO registers and models the multi-cycle latency of mult/div with a busy counter. Its busy output feeds the D-stage stall logic, and its read port feeds the E-stage write-data mux (WDSel = MD).

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu/madd/maddu/msub/msubu (must be >= 1)
DIV_CYCLES, 10, busy duration for div/divu (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
enMDU  input  1  start strobe from E-stage decode (op writes HI/LO)
MDUOp  input  4  op code from shared constants: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU
A  input  32  forwarded rs value
B  input  32  forwarded rt value
req  input  1  exception/interrupt flush of the E-stage instruction this cycle
busy  output  1  multi-cycle operation in progress
MDOut  output  32  HI when MDUOp = MFHI, LO when MDUOp = MFLO, else 0 (combinational)
HI  output  32  current HI register
LO  output  32  current LO register

Behaviour:
- Reset, async: busy=0, HI=0, LO=0, internal counter=0, captured operands=0. Reset mid-operation discards the pending result.
- Effective start: go = enMDU & ~req & ~busy.
- States: IDLE (busy=0), BUSY (busy=1). The counter holds the remaining cycles.
- IDLE, go with MULT/MULTU/MADD/MADDU/MSUB/MSUBU: capture A, B and op; cnt <= MULT_CYCLES; busy <= 1 at the same edge.
- IDLE, go with DIV/DIVU: same, with cnt <= DIV_CYCLES.
- IDLE, go with MTHI/MTLO: HI <= A or LO <= A at that edge. No busy.
- BUSY: cnt decrements each edge. At the edge where cnt==1, HI/LO are written and busy <= 0. busy is therefore high for exactly N cycles after the start edge. Results become visible on HI/LO/MDOut in the first cycle busy=0.
- Result rules (all wrap mod 2^64):
  - MULT: {HI,LO} = signed A*B, 64-bit.
  - MULTU: {HI,LO} = unsigned A*B, 64-bit.
  - MADD: {HI,LO} += signed product. MADDU: unsigned product.
  - MSUB: {HI,LO} -= signed product. MSUBU: unsigned product.
  - The accumulate base is {HI,LO} at the completion edge.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: HI/LO unchanged; busy still lasts DIV_CYCLES.
- enMDU while busy: ignored, including MTHI/MTLO. The D stage guarantees a stall; the bench flags it as an assertion.
- req asserted with enMDU: no state change. req during BUSY does not cancel the operation (it is already committed).
- MFHI/MFLO read combinationally and are legal in IDLE only. During BUSY, MDOut still shows the old HI/LO, and the stall unit prevents use.
- enMDU=0 with MDUOp = MFHI/MFLO/NOP: no state change.

Optional Feature:
MDU_MADD_EN
- Defined: MADD/MADDU/MSUB/MSUBU behave as above.
- Undefined: op codes 9-12 are treated as NOP. There is no busy, HI/LO are unchanged, and the accumulate datapath is not synthesized.

Test Plan:
- MULT A=0xFFFFFFFF B=0x00000002 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7 B=0 -> HI/LO unchanged, busy still 10 cycles.
- MTHI A=0x12345678, next cycle MFHI -> MDOut=0x12345678 with no busy. MTLO with enMDU and req both high -> LO unchanged.
- HI=0, LO=0xFFFFFFFF, MADDU A=1 B=1 -> HI=0x00000001, LO=0x00000000. Then MSUB A=1 B=1 -> HI=0x00000000, LO=0xFFFFFFFF. Without MDU_MADD_EN -> no busy and no change.
- MULT started, reset pulsed in cycle 3 of BUSY -> busy=0 and HI=LO=0 immediately (async); no late write afterwards.
- MULT started, second enMDU MULT issued in cycle 2 of BUSY -> ignored; the final result reflects the first operands only, and busy still ends at cycle 5.
